// File: rtl/pc_multi_hart_pkg.sv
// rtl/pc_multi_hart_pkg.sv - shared defines for the multi-hart fetch-PC unit
package pc_multi_hart_pkg;

  // Reset PC, held wide so any XLEN up to 64 can take a slice of it.
  localparam logic [63:0] PC_RST  = 64'h0000_0000_0000_0000;
  localparam int          PC_STEP = 4;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
  } pc_req_t;

  // Instructions are word aligned; the low two bits of any written PC are dropped.
  function automatic logic [63:0] pc_align(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_multi_hart_rr_arbiter.sv
// rtl/pc_multi_hart_rr_arbiter.sv - combinational round-robin pick over NHART requesters
module pc_multi_hart_rr_arbiter #(
  parameter int NHART = 4,
  parameter int HW    = $clog2(NHART)
) (
  input  logic [NHART-1:0] req_i,
  input  logic [HW-1:0]    last_i,
  output logic [HW-1:0]    grant_o,
  output logic             any_grant_o
);

  logic [HW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after last_i wins.
  always_comb begin
    grant_o     = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int k = NHART; k >= 1; k--) begin
      idx = last_i + HW'(k);
      if (req_i[idx]) begin
        grant_o     = idx;
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_multi_hart.sv
// rtl/pc_multi_hart.sv - per-hart program counters with round-robin fetch issue
module pc_multi_hart
  import pc_multi_hart_pkg::*;
#(
  parameter int               XLEN    = 32,
  parameter int               NHART   = 4,
  parameter int               HW      = $clog2(NHART),
  parameter logic [XLEN-1:0]  RST_VEC = PC_RST[XLEN-1:0],
  parameter int               INC     = PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [NHART-1:0] hart_en,
  input  logic             redir_valid,
  input  logic [HW-1:0]    redir_hart,
  input  logic [XLEN-1:0]  redir_pc,
  output logic             fetch_valid,
  output logic [HW-1:0]    fetch_hart,
  output logic [XLEN-1:0]  fetch_pc
);

  logic [XLEN-1:0]  pc_q [NHART];
  logic [XLEN-1:0]  pc_d [NHART];
  logic [HW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             fv_q, fv_d;
  logic [HW-1:0]    fh_q, fh_d;
  logic [XLEN-1:0]  fp_q, fp_d;

  logic [NHART-1:0] eligible;
  logic [HW-1:0]    grant;
  logic             any_grant;

  // A hart being redirected this edge must not issue its stale PC.
  always_comb begin
    eligible = hart_en;
    if (redir_valid) begin
      eligible[redir_hart] = 1'b0;
    end
  end

  pc_multi_hart_rr_arbiter #(
    .NHART (NHART),
    .HW    (HW)
  ) u_arb (
    .req_i       (eligible),
    .last_i      (rr_ptr_q),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  always_comb begin
    pc_d     = pc_q;
    rr_ptr_d = rr_ptr_q;
    fv_d     = fv_q;
    fh_d     = fh_q;
    fp_d     = fp_q;

    if (redir_valid) begin
      pc_d[redir_hart] = redir_pc & ~XLEN'(3);
    end

    if (!stall) begin
      if (bubble) begin
        fv_d = 1'b0;
      end else if (any_grant) begin
        fv_d        = 1'b1;
        fh_d        = grant;
        fp_d        = pc_q[grant];
        pc_d[grant] = pc_q[grant] + XLEN'(INC);
        rr_ptr_d    = grant;
      end else begin
        fv_d = 1'b0;
      end
    end
  end

  // rr_ptr resets to the last hart so hart 0 is first to issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NHART; i++) begin
        pc_q[i] <= RST_VEC;
      end
      rr_ptr_q <= HW'(NHART - 1);
      fv_q     <= 1'b0;
      fh_q     <= '0;
      fp_q     <= '0;
    end else begin
      for (int i = 0; i < NHART; i++) begin
        pc_q[i] <= pc_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      fv_q     <= fv_d;
      fh_q     <= fh_d;
      fp_q     <= fp_d;
    end
  end

  assign fetch_valid = fv_q;
  assign fetch_hart  = fh_q;
  assign fetch_pc    = fp_q;

endmodule

// File: tb/tb_pc_multi_hart.sv
// tb/tb_pc_multi_hart.sv - scoreboard bench for the multi-hart fetch-PC unit
module tb_pc_multi_hart;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        bubble;
  logic [3:0]  hart_en;
  logic        redir_valid;
  logic [1:0]  redir_hart;
  logic [31:0] redir_pc;
  logic        fetch_valid;
  logic [1:0]  fetch_hart;
  logic [31:0] fetch_pc;

  pc_multi_hart dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .bubble      (bubble),
    .hart_en     (hart_en),
    .redir_valid (redir_valid),
    .redir_hart  (redir_hart),
    .redir_pc    (redir_pc),
    .fetch_valid (fetch_valid),
    .fetch_hart  (fetch_hart),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [1:0]  fh;
    logic [31:0] fp;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] m_pc [4];
  int          m_ptr;
  logic        m_fv;
  logic [1:0]  m_fh;
  logic [31:0] m_fp;

  logic [31:0] h_log[$];
  logic [1:0]  h_hart[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pc[i] = 32'h0;
    m_ptr = 3;
    m_fv  = 1'b0;
    m_fh  = 2'd0;
    m_fp  = 32'h0;
  endtask

  task automatic step(input logic s, input logic b, input logic [3:0] en,
                      input logic rv, input logic [1:0] rh, input logic [31:0] rp);
    exp_t        e;
    logic [3:0]  elig;
    logic [31:0] old_pc [4];
    int          pick;
    stall = s; bubble = b; hart_en = en;
    redir_valid = rv; redir_hart = rh; redir_pc = rp;

    for (int i = 0; i < 4; i++) old_pc[i] = m_pc[i];
    elig = en;
    if (rv) begin
      elig[rh] = 1'b0;
      m_pc[rh] = {rp[31:2], 2'b00};
    end
    if (!s) begin
      if (b) begin
        m_fv = 1'b0;
      end else begin
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
          if (pick < 0 && elig[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        end
        if (pick >= 0) begin
          m_fv = 1'b1;
          m_fh = 2'(pick);
          m_fp = old_pc[pick];
          m_pc[pick] = old_pc[pick] + 32'd4;
          m_ptr = pick;
        end else begin
          m_fv = 1'b0;
        end
      end
    end
    e.fv = m_fv; e.fh = m_fh; e.fp = m_fp;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("fetch_valid", 64'(fetch_valid), 64'(e.fv));
    check("fetch_hart", 64'(fetch_hart), 64'(e.fh));
    check("fetch_pc", 64'(fetch_pc), 64'(e.fp));
    if (fetch_valid) begin
      h_hart.push_back(fetch_hart);
      h_log.push_back(fetch_pc);
    end
  endtask

  task automatic run(input logic [3:0] en);
    step(1'b0, 1'b0, en, 1'b0, 2'd0, 32'h0);
  endtask

  // Reset lands mid-cycle and is checked before the next clock edge.
  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    check("rst_fv", 64'(fetch_valid), 64'd0);
    check("rst_fh", 64'(fetch_hart), 64'd0);
    check("rst_fp", 64'(fetch_pc), 64'd0);
    #2 rst = 1'b1;
    model_reset();
    h_log.delete();
    h_hart.delete();
  endtask

  initial begin : main
    logic [1:0]  t1_h [6];
    logic [31:0] t1_p [6];
    logic [31:0] h1_pcs[$];
    logic [31:0] h0_pcs[$];
    int          cnt;

    t1_h = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    t1_p = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4};

    rst = 1'b0; stall = 1'b0; bubble = 1'b0; hart_en = 4'h0;
    redir_valid = 1'b0; redir_hart = 2'd0; redir_pc = 32'h0;
    @(posedge clk);
    #1;
    async_reset();

    // 1: all harts enabled
    for (int i = 0; i < 6; i++) begin
      run(4'b1111);
      check("t1_hart", 64'(fetch_hart), 64'(t1_h[i]));
      check("t1_pc", 64'(fetch_pc), 64'(t1_p[i]));
    end

    // 2: harts 1 and 3 only, then a fully masked gap
    async_reset();
    for (int i = 0; i < 4; i++) run(4'b1010);
    check("t2_seq_len", 64'(h_hart.size()), 64'd4);
    if (h_hart.size() == 4) begin
      check("t2_h0", 64'(h_hart[0]), 64'd1);
      check("t2_h1", 64'(h_hart[1]), 64'd3);
      check("t2_p2", 64'(h_log[2]), 64'h4);
      check("t2_p3", 64'(h_log[3]), 64'h4);
    end
    run(4'b0000);
    run(4'b0000);
    check("t2_idle_fv", 64'(fetch_valid), 64'd0);
    run(4'b1111);
    check("t2_resume_h", 64'(fetch_hart), 64'd0);
    check("t2_resume_pc", 64'(fetch_pc), 64'h0);

    // 3: stall three cycles, redirect hart2 in the middle one
    run(4'b1111);
    run(4'b1111);
    step(1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 32'h0);
    step(1'b1, 1'b0, 4'b1111, 1'b1, 2'd2, 32'h100);
    step(1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 32'h0);
    h_log.delete();
    h_hart.delete();
    for (int i = 0; i < 4; i++) run(4'b1111);
    cnt = 0;
    foreach (h_hart[i]) if (h_hart[i] == 2'd2 && h_log[i] == 32'h100) cnt++;
    check("t3_h2_redir", 64'(cnt), 64'd1);

    // 4: redirect hart1 on the very cycle it would be chosen
    for (int i = 0; i < 4 && m_ptr != 0; i++) run(4'b1111);
    step(1'b0, 1'b0, 4'b1111, 1'b1, 2'd1, 32'h203);
    check("t4_skip", 64'(fetch_hart), 64'd2);
    h_log.delete();
    h_hart.delete();
    for (int i = 0; i < 8; i++) run(4'b1111);
    foreach (h_hart[i]) if (h_hart[i] == 2'd1) h1_pcs.push_back(h_log[i]);
    check("t4_h1_cnt", 64'(h1_pcs.size()), 64'd2);
    if (h1_pcs.size() >= 2) begin
      check("t4_h1_a", 64'(h1_pcs[0]), 64'h200);
      check("t4_h1_b", 64'(h1_pcs[1]), 64'h204);
    end

    // 5: hart0 wraps past the top of the address space
    step(1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 32'hFFFF_FFFC);
    h_log.delete();
    h_hart.delete();
    for (int i = 0; i < 8; i++) run(4'b1111);
    foreach (h_hart[i]) if (h_hart[i] == 2'd0) h0_pcs.push_back(h_log[i]);
    check("t5_h0_cnt", 64'(h0_pcs.size()), 64'd2);
    if (h0_pcs.size() >= 2) begin
      check("t5_top", 64'(h0_pcs[0]), 64'hFFFF_FFFC);
      check("t5_wrap", 64'(h0_pcs[1]), 64'h0);
    end

    // stall and bubble together: stall wins
    step(1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 32'h0);
    check("sb_hold_fv", 64'(fetch_valid), 64'd1);

    // 6: bubble, then asynchronous reset
    step(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 32'h0);
    check("t6_bubble_fv", 64'(fetch_valid), 64'd0);
    run(4'b1111);
    async_reset();
    run(4'b1111);
    check("t6_post_h", 64'(fetch_hart), 64'd0);
    check("t6_post_pc", 64'(fetch_pc), 64'h0);
    run(4'b1111);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 4'($urandom),
           ($urandom_range(0, 3) == 0), 2'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_multi_hart.md
Name: pc_multi_hart

Overview:
Parametrised fetch-PC unit for the multi-hart pipeline front end. It holds one program counter per hardware thread (hart) and picks one enabled hart per cycle by round-robin. It presents that hart's PC to instruction fetch and post-increments it. It keeps the stall/bubble hold semantics of the single-hart PC and adds per-hart redirect plus hart enable masking.

Parameters:
XLEN, 32, PC and address width
NHART, 4, number of harts (power of two, >=2)
HW, $clog2(NHART), hart index width
RST_VEC, PC_RST from shared defines, reset value of every hart PC
INC, 4, post-issue increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
stall  in  1  freeze: hold all PCs, pointer and fetch outputs
bubble  in  1  issue nothing this cycle: fetch_valid<=0, PCs and pointer hold
hart_en  in  NHART  per-hart eligibility mask (1 = may be scheduled)
redir_valid  in  1  redirect request (branch/jump/trap)
redir_hart  in  HW  hart being redirected
redir_pc  in  XLEN  new PC for redir_hart
fetch_valid  out  1  fetch_pc/fetch_hart valid this cycle
fetch_hart  out  HW  hart issued
fetch_pc  out  XLEN  PC issued to fetch

Behaviour:
- Reset (rst=0, async): pc[i]=RST_VEC for all i; rr_ptr=NHART-1 so hart 0 is issued first; fetch_valid=0, fetch_hart=0, fetch_pc=0.
- Outputs are registered: a hart selected at edge N appears on fetch_* after edge N, with 1-cycle latency.
- Redirect is applied on every enabled edge, including under stall and bubble. A redirect is never dropped. redir_pc[1:0] is forced to 0 on write.
- Priority per edge: reset > stall > bubble > normal issue. Redirect is orthogonal to all three.
- stall=1: fetch_* and rr_ptr hold. PCs hold except the redirect write.
- bubble=1 (stall=0): fetch_valid<=0 while fetch_pc/fetch_hart hold. rr_ptr holds. PCs hold except the redirect write.
- Normal issue:
  - eligible = hart_en with bit redir_hart cleared when redir_valid=1. A hart whose PC is being redirected is never issued with its stale PC.
  - h = first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NHART.
  - On a hit: fetch_valid<=1, fetch_hart<=h, fetch_pc<=pc[h], pc[h]<=pc[h]+INC (wraps modulo 2^XLEN), rr_ptr<=h.
  - If eligible is all zero: fetch_valid<=0, rr_ptr holds.
- Redirect to a hart with hart_en=0 still updates its PC.
- Simultaneous stall and bubble: stall wins, so fetch_valid holds its previous value.
- Reset asserted mid-operation: every state element returns to its reset value immediately, independent of clk.

Decomposition:
- Shared defines: PC_RST and INC constant (PC_STEP).
- One sub-module, rr_arbiter: NHART-wide combinational round-robin pick.
  - Inputs: req mask and last-grant pointer.
  - Outputs: grant index and any_grant.
- pc_multi_hart owns the PC array, rr_ptr and the output registers.

Test Plan:
1. Reset then release, hart_en=4'b1111, no stall/bubble.
   - fetch sequence (hart,pc): (0,0),(1,0),(2,0),(3,0),(0,4),(1,4).
2. hart_en=4'b1010 from reset.
   - Issues alternate hart1/hart3 only: (1,0),(3,0),(1,4),(3,4).
   - hart_en=0 → fetch_valid=0 and rr_ptr unchanged; re-enable resumes at the next hart after the last issued.
3. Steady issue, stall high 3 cycles with a redirect of hart2 to 0x100 in the middle.
   - fetch_* frozen for 3 cycles.
   - After release, hart2's next issue shows pc 0x100; other harts continue unchanged.
4. Redirect hart1 to 0x203 in the cycle hart1 would be selected.
   - Hart1 is skipped that cycle and hart2 is issued.
   - Hart1's next issue has pc 0x200 (low bits masked), then 0x204.
5. pc[0] redirected to 0xFFFF_FFFC, then issued.
   - fetch_pc=0xFFFF_FFFC; the next hart0 issue is 0x0000_0000 (wrap).
6. bubble one cycle, then rst pulsed low asynchronously between edges.
   - Bubble gives fetch_valid=0 with no PC advance.
   - The reset pulse clears outputs immediately, and the first issue afterwards is (0,RST_VEC).
